param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Parametrised single-clock FIFO, the successor to the team's basic synchronous FIFO, for buffering matrix/vector element streams between EKF-SLAM datapath stages. Adds a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, an occupancy output, synchronous flush, and sticky overflow/underflow error flags. Occupancy tracks only accepted transfers, so rejected requests never corrupt the count.

## Interface
- DATA_LEN, 8, word width in bits
- DEPTH, 8, number of entries, ≥2; need not be a power of 2
- ADDR_WIDTH, 3, pointer width; 2^ADDR_WIDTH ≥ DEPTH
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserted when level ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when level ≤ AE_LEVEL

Reset is sys_rst_n, asynchronous, active-low. Clock is clk.

- clk  in  1  clock, all state on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of pointers/level/out_valid
- clr_err  in  1  clears sticky overflow/underflow
- wr_en  in  1  write request
- data_in  in  DATA_LEN  write data
- rd_en  in  1  read request (pop)
- data_out  out  DATA_LEN  read data
- out_valid  out  1  data_out holds valid data
- empty / full  out  1  level==0 / level==DEPTH
- almost_empty / almost_full  out  1  threshold flags
- level  out  ADDR_WIDTH+1  current occupancy 0..DEPTH
- overflow / underflow  out  1  sticky error flags

## Operation
- Accepted write: wr_ok = wr_en & ~full. Accepted read: rd_ok = rd_en & ~empty. Both use the registered flags from the start of the cycle.
- Next level = level + wr_ok − rd_ok. Flags are decoded from the level register only, with no combinational path from wr_en/rd_en.
- Pointers increment on accept and wrap DEPTH-1 → 0.
- Both requests at full: the read is accepted, the write is dropped, and overflow is set. Level goes to DEPTH-1.
- Both requests at empty: the write is accepted, the read is rejected, and underflow is set. Level goes to 1.
- Both requests otherwise: both are accepted and level is unchanged.
- overflow is set by wr_en & full; underflow is set by rd_en & empty. Both are cleared by clr_err. Set wins over clear in the same cycle.
- flush: wr_ptr, rd_ptr and level go to 0, and out_valid goes to 0. flush dominates wr_en/rd_en in the same cycle. Memory contents are untouched and error flags are unaffected.
- Standard mode (FWFT=0):
  - On rd_ok, data_out is loaded from mem[rd_ptr] and out_valid is 1 the next cycle.
  - Without rd_ok, out_valid is 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr], combinational from the memory.
  - out_valid = ~empty.
  - rd_ok consumes the presented word.
- Memory is not reset. Reads of never-written entries are not possible because empty gates them.

## Timing
- Reset values: data_out 0, out_valid 0, empty 1, full 0, almost_empty 1, almost_full (AF_LEVEL==0), level 0, overflow 0, underflow 0.
- Write-to-empty-deassert latency: 1 cycle (the edge that accepts the write).
- Standard mode read latency: 1 cycle from rd_ok to data_out/out_valid.
- FWFT mode:
  - First-word latency is 1 cycle after the accepting write edge.
  - The following word appears in the same cycle as the pop edge.
- A read and a write to the same entry in one cycle are impossible by construction (empty/full gating).
- Asynchronous reset mid-operation clears all state immediately. There is no recovery of buffered data.

## Structure
- The shared package fifo_pkg holds a clog2 function and the level-width localparam, reused by other FIFO users.
- Sub-module fifo_mem: DEPTH×DATA_LEN, one synchronous write port, one asynchronous read port, no reset.
- The top level holds the pointers, level, flags, error logic and the FWFT/standard output path, selected by a generate on FWFT.

## Test plan
- Fill and drain, DEPTH=8, standard mode. Write 8 words (0x11..0x18), then read 8.
  - full=1 at level 8.
  - Reads return 0x11..0x18, each with out_valid one cycle after rd_en.
  - empty=1 at the end.
- Thresholds, AF_LEVEL=6, AE_LEVEL=2. Fill one word at a time.
  - almost_empty drops at level 3; almost_full rises at level 6.
  - Draining reverses both exactly.
- Simultaneous requests at full and at empty.
  - At full: level 8 → 7, overflow=1, the dropped word never appears.
  - At empty: level 0 → 1, underflow=1.
  - clr_err together with a new error leaves the flag at 1.
- Wrap-around, DEPTH=6, ADDR_WIDTH=3. Run 20 interleaved writes/reads with level kept at 3.
  - Data order is preserved and pointers never reach 6.
- FWFT=1. Write 0xA5 then 0x5A.
  - out_valid=1 and data_out=0xA5 one cycle after the first write.
  - After the pop, data_out=0x5A.
- Flush with 4 entries plus concurrent wr_en.
  - The next cycle shows level 0, empty=1, out_valid 0.
  - The concurrent write is ignored and the error flags are unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: ceiling log2 and occupancy-counter sizing, reused by every FIFO user.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEF_DEPTH = 8;
  localparam int DEF_LVL_W = clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/param_sync_fifo_if.sv
// Request/response bundle between a producer/consumer pair and param_sync_fifo.
// master drives requests and write data; slave (the FIFO) returns data, occupancy and flags.
interface param_sync_fifo_if #(
  parameter int DATA_LEN = 8,
  parameter int LVL_W    = fifo_pkg::DEF_LVL_W
);
  logic                flush;
  logic                clr_err;
  logic                wr_en;
  logic [DATA_LEN-1:0] data_in;
  logic                rd_en;
  logic [DATA_LEN-1:0] data_out;
  logic                out_valid;
  logic                empty;
  logic                full;
  logic                almost_empty;
  logic                almost_full;
  logic [LVL_W-1:0]    level;
  logic                overflow;
  logic                underflow;

  modport master (
    output flush, clr_err, wr_en, data_in, rd_en,
    input  data_out, out_valid, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, data_in, rd_en,
    output data_out, out_valid, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_LEN storage: one synchronous write port, one asynchronous read port, no reset.
// Write lands on the rising edge; read data follows raddr combinationally.
module fifo_mem #(
  parameter int DATA_LEN   = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_LEN-1:0]   wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_LEN-1:0]   rdata
);
  logic [DATA_LEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with FWFT/registered read, threshold flags, flush and sticky errors.
// Latency 1 cycle write-to-visible and rd-to-data; full drops writes, empty rejects reads.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_LEN   = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic              clk,
  input logic              sys_rst_n,
  param_sync_fifo_if.slave bus
);
  localparam int LVL_W = level_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic                  empty;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  mem_we;
  logic [DATA_LEN-1:0]   rd_data;
  logic                  overflow_q;
  logic                  underflow_q;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Flags come straight from the level register, never from this cycle's requests.
  assign empty  = (level_q == '0);
  assign full   = (level_q == LVL_W'(DEPTH));
  assign wr_ok  = bus.wr_en & ~full;
  assign rd_ok  = bus.rd_en & ~empty;
  assign mem_we = wr_ok & ~bus.flush;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (bus.wr_en & full)  | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
    end
  end

  fifo_mem #(
    .DATA_LEN   (DATA_LEN),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out  = rd_data;
      assign bus.out_valid = ~empty;
    end else begin : g_std
      logic [DATA_LEN-1:0] dout_q;
      logic                oval_q;

      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          dout_q <= '0;
          oval_q <= 1'b0;
        end else begin
          oval_q <= rd_ok & ~bus.flush;
          if (rd_ok & ~bus.flush) dout_q <= rd_data;
        end
      end

      assign bus.data_out  = dout_q;
      assign bus.out_valid = oval_q;
    end
  endgenerate

  assign bus.level        = level_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (int'(level_q) <= AE_LEVEL);
  assign bus.almost_full  = (int'(level_q) >= AF_LEVEL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Three FIFO instances: 0 = depth 8 registered, 1 = depth 6 registered, 2 = depth 8 FWFT.
module tb_param_sync_fifo;
  localparam int AEL = 2;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] wr_en, rd_en, flush, clr_err;
  logic [7:0] din  [3];
  logic [7:0] dout [3];
  logic [3:0] lvl  [3];
  logic [2:0] oval, emp, ful, ae_o, af_o, ovf, unf;
  logic       ptr_ok;

  int errors = 0;
  int checks = 0;

  function automatic int dep(input int k);
    return (k == 1) ? 6 : 8;
  endfunction

  function automatic int afl(input int k);
    return (k == 1) ? 4 : 6;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    param_sync_fifo_if #(.DATA_LEN(8), .LVL_W(4)) bus ();

    param_sync_fifo #(
      .DATA_LEN   (8),
      .DEPTH      (g == 1 ? 6 : 8),
      .ADDR_WIDTH (3),
      .FWFT       (g == 2 ? 1 : 0),
      .AF_LEVEL   (g == 1 ? 4 : 6),
      .AE_LEVEL   (AEL)
    ) u_dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
    );

    assign bus.wr_en   = wr_en[g];
    assign bus.rd_en   = rd_en[g];
    assign bus.flush   = flush[g];
    assign bus.clr_err = clr_err[g];
    assign bus.data_in = din[g];
    assign dout[g]     = bus.data_out;
    assign lvl[g]      = bus.level;
    assign oval[g]     = bus.out_valid;
    assign emp[g]      = bus.empty;
    assign ful[g]      = bus.full;
    assign ae_o[g]     = bus.almost_empty;
    assign af_o[g]     = bus.almost_full;
    assign ovf[g]      = bus.overflow;
    assign unf[g]      = bus.underflow;
  end

  assign ptr_ok = (g_dut[1].u_dut.wr_ptr < 3'd6) && (g_dut[1].u_dut.rd_ptr < 3'd6);

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d] at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue per instance plus sticky flags and registered-read output.
  logic [7:0] mq [3][$];
  logic       m_ovf  [3];
  logic       m_unf  [3];
  logic       m_oval [3];
  logic [7:0] m_dout [3];

  initial begin : model
    int n;
    for (int k = 0; k < 3; k++) begin
      m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_oval[k] = 1'b0; m_dout[k] = 8'h00;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!sys_rst_n) begin
          mq[k].delete();
          m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_oval[k] = 1'b0; m_dout[k] = 8'h00;
        end else begin
          n = mq[k].size();
          m_ovf[k] = (wr_en[k] && n == dep(k)) || (m_ovf[k] && !clr_err[k]);
          m_unf[k] = (rd_en[k] && n == 0) || (m_unf[k] && !clr_err[k]);
          if (flush[k]) begin
            mq[k].delete();
            m_oval[k] = 1'b0;
          end else begin
            if (rd_en[k] && n > 0) begin
              m_dout[k] = mq[k].pop_front();
              m_oval[k] = 1'b1;
            end else begin
              m_oval[k] = 1'b0;
            end
            if (wr_en[k] && n < dep(k)) mq[k].push_back(din[k]);
          end
        end
      end
    end
  end

  initial begin : compare
    int n;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n = mq[k].size();
        chk("level", k, 32'(lvl[k]), n);
        chk("empty", k, 32'(emp[k]), 32'(n == 0));
        chk("full", k, 32'(ful[k]), 32'(n == dep(k)));
        chk("almost_empty", k, 32'(ae_o[k]), 32'(n <= AEL));
        chk("almost_full", k, 32'(af_o[k]), 32'(n >= afl(k)));
        chk("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
        chk("underflow", k, 32'(unf[k]), 32'(m_unf[k]));
        if (k == 2) begin
          chk("out_valid", k, 32'(oval[k]), 32'(n != 0));
          if (n != 0) chk("data_out", k, 32'(dout[k]), 32'(mq[k][0]));
        end else begin
          chk("out_valid", k, 32'(oval[k]), 32'(m_oval[k]));
          chk("data_out", k, 32'(dout[k]), 32'(m_dout[k]));
        end
      end
      chk("ptr_range", 1, 32'(ptr_ok), 32'd1);
    end
  end

  task automatic step(input int k, input logic w, input logic [7:0] d, input logic r,
                      input logic f = 1'b0, input logic c = 1'b0);
    wr_en[k] = w; din[k] = d; rd_en[k] = r; flush[k] = f; clr_err[k] = c;
    @(posedge clk);
    #1;
    wr_en[k] = 1'b0; rd_en[k] = 1'b0; flush[k] = 1'b0; clr_err[k] = 1'b0;
  endtask

  initial begin : stimulus
    wr_en = '0; rd_en = '0; flush = '0; clr_err = '0;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 0, 32'(lvl[0]), 32'd0);
    chk("rst_empty", 0, 32'(emp[0]), 32'd1);
    chk("rst_full", 0, 32'(ful[0]), 32'd0);
    chk("rst_ae", 0, 32'(ae_o[0]), 32'd1);
    chk("rst_af", 0, 32'(af_o[0]), 32'd0);
    chk("rst_oval", 0, 32'(oval[0]), 32'd0);
    chk("rst_dout", 0, 32'(dout[0]), 32'd0);
    chk("rst_err", 0, 32'({ovf[0], unf[0]}), 32'd0);
    sys_rst_n = 1'b1;

    // Fill and drain with threshold tracking
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, 8'(8'h11 + i), 1'b0);
      chk("fill_ae", 0, 32'(ae_o[0]), 32'(i + 1 <= 2));
      chk("fill_af", 0, 32'(af_o[0]), 32'(i + 1 >= 6));
    end
    chk("fill_full", 0, 32'(ful[0]), 32'd1);
    chk("fill_level", 0, 32'(lvl[0]), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 8'h00, 1'b1);
      chk("drain_valid", 0, 32'(oval[0]), 32'd1);
      chk("drain_data", 0, 32'(dout[0]), 32'(8'h11 + i));
      chk("drain_ae", 0, 32'(ae_o[0]), 32'(7 - i <= 2));
      chk("drain_af", 0, 32'(af_o[0]), 32'(7 - i >= 6));
    end
    step(0, 1'b0, 8'h00, 1'b0);
    chk("drain_empty", 0, 32'(emp[0]), 32'd1);
    chk("drain_oval_off", 0, 32'(oval[0]), 32'd0);

    // Simultaneous requests at full, then at empty
    for (int i = 0; i < 8; i++) step(0, 1'b1, 8'(8'h21 + i), 1'b0);
    step(0, 1'b1, 8'hEE, 1'b1);
    chk("full_both_level", 0, 32'(lvl[0]), 32'd7);
    chk("full_both_ovf", 0, 32'(ovf[0]), 32'd1);
    chk("full_both_data", 0, 32'(dout[0]), 32'h21);
    for (int i = 0; i < 7; i++) begin
      step(0, 1'b0, 8'h00, 1'b1);
      chk("after_ovf_data", 0, 32'(dout[0]), 32'(8'h22 + i));
    end
    step(0, 1'b1, 8'h77, 1'b1);
    chk("empty_both_level", 0, 32'(lvl[0]), 32'd1);
    chk("empty_both_unf", 0, 32'(unf[0]), 32'd1);
    chk("empty_both_oval", 0, 32'(oval[0]), 32'd0);
    step(0, 1'b0, 8'h00, 1'b1);
    chk("empty_both_data", 0, 32'(dout[0]), 32'h77);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("clr_vs_set_unf", 0, 32'(unf[0]), 32'd1);
    chk("clr_ovf", 0, 32'(ovf[0]), 32'd0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_unf", 0, 32'(unf[0]), 32'd0);

    // Flush with four entries and a concurrent write
    step(0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'h41 + i), 1'b0);
    step(0, 1'b0, 8'h00, 1'b1);
    chk("pre_flush_level", 0, 32'(lvl[0]), 32'd4);
    step(0, 1'b1, 8'h99, 1'b1, 1'b1);
    chk("flush_level", 0, 32'(lvl[0]), 32'd0);
    chk("flush_empty", 0, 32'(emp[0]), 32'd1);
    chk("flush_oval", 0, 32'(oval[0]), 32'd0);
    chk("flush_unf_kept", 0, 32'(unf[0]), 32'd1);
    chk("flush_dout_held", 0, 32'(dout[0]), 32'h41);
    step(0, 1'b1, 8'h55, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1);
    chk("post_flush_data", 0, 32'(dout[0]), 32'h55);

    // Wrap-around on the depth-6 instance at constant occupancy 3
    for (int i = 0; i < 3; i++) step(1, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1'b1, 8'(8'h33 + i), 1'b1);
      chk("wrap_data", 1, 32'(dout[1]), 32'(8'h30 + i));
      chk("wrap_level", 1, 32'(lvl[1]), 32'd3);
    end

    // First-word-fall-through
    step(2, 1'b1, 8'hA5, 1'b0);
    chk("fwft_first_valid", 2, 32'(oval[2]), 32'd1);
    chk("fwft_first_data", 2, 32'(dout[2]), 32'hA5);
    step(2, 1'b1, 8'h5A, 1'b0);
    chk("fwft_hold_data", 2, 32'(dout[2]), 32'hA5);
    step(2, 1'b0, 8'h00, 1'b1);
    chk("fwft_pop_data", 2, 32'(dout[2]), 32'h5A);
    chk("fwft_pop_level", 2, 32'(lvl[2]), 32'd1);
    step(2, 1'b0, 8'h00, 1'b1);
    chk("fwft_drained", 2, 32'(oval[2]), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
